// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: instruction width, NOP encoding, PC step and FSM/PC-select encodings.
package riscv_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [INSTR_W-1:0] PC_INC    = 32'h0000_0004;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_SEL_RESET  = 2'd0,
        PC_SEL_BRANCH = 2'd1,
        PC_SEL_INC    = 2'd2,
        PC_SEL_HOLD   = 2'd3
    } pc_sel_e;

    // Redirect targets are word aligned by dropping the byte-offset bits.
    function automatic logic [INSTR_W-1:0] align_word(input logic [INSTR_W-1:0] addr);
        return {addr[INSTR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_next.sv
// Next-PC selector: reset PC, word-aligned redirect target, sequential PC+4, or hold.
import riscv_pkg::*;

module pc_next #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  pc_sel_e     sel,
    input  logic [31:0] pc,
    input  logic [31:0] branch_target,
    output logic [31:0] pc_nxt
);

    // Pure mux; PC+4 wraps naturally modulo 2^32.
    always_comb begin
        pc_nxt = pc;
        case (sel)
            PC_SEL_RESET:  pc_nxt = RESET_PC;
            PC_SEL_BRANCH: pc_nxt = align_word(branch_target);
            PC_SEL_INC:    pc_nxt = pc + PC_INC;
            PC_SEL_HOLD:   pc_nxt = pc;
            default:       pc_nxt = pc;
        endcase
    end

endmodule

// File: rtl/fetch_fsm.sv
// Instruction fetch FSM with stall/redirect handling.
// Optional macro FETCH_MISALIGN_CHECK_EN: misaligned redirect halts in S_FAULT instead of being aligned.
import riscv_pkg::*;

module fetch_fsm #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] IR_out,
    output logic [31:0] PC_out,
    output logic        valid_out,
    output logic        fault
);

    localparam logic [1:0] S_REQ   = ST_REQ;
    localparam logic [1:0] S_HOLD  = ST_HOLD;
    localparam logic [1:0] S_FAULT = ST_FAULT;

    logic [1:0]  state_r;
    logic [1:0]  state_nxt;
    logic [31:0] pc_r;
    logic [31:0] pc_nxt_s;
    pc_sel_e     pc_sel_s;
    logic        load_out_s;
    logic        clr_valid_s;
    logic        set_fault_s;
    logic        misaligned_s;
    logic        req_r;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misaligned_s = (branch_target[1:0] != 2'b00);
`else
    assign misaligned_s = 1'b0;
`endif

    pc_next #(.RESET_PC(RESET_PC)) u_pc_next (
        .sel           (pc_sel_s),
        .pc            (pc_r),
        .branch_target (branch_target),
        .pc_nxt        (pc_nxt_s)
    );

    // Next-state decode; priority is redirect, then stall, then memory ack.
    always_comb begin
        state_nxt   = state_r;
        pc_sel_s    = PC_SEL_HOLD;
        load_out_s  = 1'b0;
        clr_valid_s = 1'b0;
        set_fault_s = 1'b0;
        if (branch_taken && (state_r != S_FAULT)) begin
            clr_valid_s = 1'b1;
            if (misaligned_s) begin
                set_fault_s = 1'b1;
                state_nxt   = S_FAULT;
            end else begin
                pc_sel_s  = PC_SEL_BRANCH;
                state_nxt = S_REQ;
            end
        end else begin
            case (state_r)
                S_REQ: begin
                    if (stall && valid_out) begin
                        state_nxt = S_HOLD;
                    end else if (imem_ack) begin
                        load_out_s = 1'b1;
                        pc_sel_s   = PC_SEL_INC;
                    end else if (!stall) begin
                        clr_valid_s = 1'b1;
                    end else begin
                        state_nxt = S_REQ;
                    end
                end
                // Held word is consumed on the edge stall drops, so no duplicate is presented.
                S_HOLD: begin
                    if (!stall) begin
                        state_nxt   = S_REQ;
                        clr_valid_s = 1'b1;
                    end else begin
                        state_nxt = S_HOLD;
                    end
                end
                S_FAULT: state_nxt = S_FAULT;
                default: state_nxt = S_REQ;
            endcase
        end
    end

    // State, PC and output registers; rst abandons any outstanding request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_REQ;
            pc_r      <= RESET_PC;
            req_r     <= 1'b1;
            IR_out    <= NOP_INSTR;
            PC_out    <= 32'h0000_0000;
            valid_out <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state_r <= state_nxt;
            pc_r    <= pc_nxt_s;
            req_r   <= (state_nxt == S_REQ);
            if (load_out_s) begin
                IR_out    <= imem_rdata;
                PC_out    <= pc_r;
                valid_out <= 1'b1;
            end else if (clr_valid_s) begin
                valid_out <= 1'b0;
            end else begin
                valid_out <= valid_out;
            end
            if (set_fault_s) begin
                fault <= 1'b1;
            end else begin
                fault <= fault;
            end
        end
    end

    assign imem_req  = req_r;
    assign imem_addr = pc_r;

endmodule

// File: tb/tb_fetch_fsm.sv
// Directed self-checking bench for fetch_fsm (default RESET_PC plus a wrap-around RESET_PC instance).
module tb_fetch_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ack;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;

    logic        req_a, valid_a, fault_a;
    logic [31:0] addr_a, rdata_a, ir_a, pcout_a;
    logic        req_b, valid_b, fault_b;
    logic [31:0] addr_b, rdata_b, ir_b, pcout_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Memory model: instruction word equals its address.
    assign rdata_a = addr_a;
    assign rdata_b = addr_b;

    fetch_fsm #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .imem_req(req_a), .imem_addr(addr_a), .imem_rdata(rdata_a),
        .imem_ack(imem_ack), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .IR_out(ir_a), .PC_out(pcout_a),
        .valid_out(valid_a), .fault(fault_a)
    );

    fetch_fsm #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .imem_req(req_b), .imem_addr(addr_b), .imem_rdata(rdata_b),
        .imem_ack(imem_ack), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .IR_out(ir_b), .PC_out(pcout_b),
        .valid_out(valid_b), .fault(fault_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_addr"}, addr_a, 32'h0000_0000);
        chk({tag, "_ir"}, ir_a, 32'h0000_0013);
        chk({tag, "_pc"}, pcout_a, 32'h0000_0000);
        chk1({tag, "_valid"}, valid_a, 1'b0);
        chk1({tag, "_fault"}, fault_a, 1'b0);
        chk1({tag, "_req"}, req_a, 1'b1);
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; stall = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0000_0000;
        #1;
        chk_reset_a("rst0");
        chk("rst0_addr_b", addr_b, 32'hFFFF_FFFC);

        #11;
        rst = 1'b0;
        imem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("seq_ir", ir_a, 32'(4 * i));
            chk("seq_pc", pcout_a, 32'(4 * i));
            chk1("seq_valid", valid_a, 1'b1);
            chk("seq_addr", addr_a, 32'(4 * i + 4));
            if (i == 0) begin
                chk("wrap_pc_b", pcout_b, 32'hFFFF_FFFC);
                chk("wrap_ir_b", ir_b, 32'hFFFF_FFFC);
                chk("wrap_addr_b", addr_b, 32'h0000_0000);
            end
        end

        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_ir", ir_a, 32'h0000_000C);
            chk("stall_pc", pcout_a, 32'h0000_000C);
            chk1("stall_valid", valid_a, 1'b1);
            chk1("stall_req", req_a, 1'b0);
            chk("stall_addr", addr_a, 32'h0000_0010);
        end
        stall = 1'b0;
        tick();
        chk1("resume_req", req_a, 1'b1);
        chk("resume_addr", addr_a, 32'h0000_0010);
        chk("resume_ir", ir_a, 32'h0000_000C);
        tick();
        chk("resume_fetch_ir", ir_a, 32'h0000_0010);
        chk("resume_fetch_pc", pcout_a, 32'h0000_0010);
        chk1("resume_fetch_valid", valid_a, 1'b1);
        chk("resume_fetch_addr", addr_a, 32'h0000_0014);

        branch_taken = 1'b1; branch_target = 32'h0000_0100;
        tick();
        branch_taken = 1'b0;
        chk1("br_valid", valid_a, 1'b0);
        chk("br_addr", addr_a, 32'h0000_0100);
        chk("br_ir_dropped", ir_a, 32'h0000_0010);
        tick();
        chk("br_fetch_ir", ir_a, 32'h0000_0100);
        chk("br_fetch_pc", pcout_a, 32'h0000_0100);
        chk1("br_fetch_valid", valid_a, 1'b1);
        chk("br_fetch_addr", addr_a, 32'h0000_0104);

        imem_ack = 1'b0;
        tick();
        chk1("bubble_valid", valid_a, 1'b0);
        chk("bubble_ir", ir_a, 32'h0000_0100);
        chk("bubble_addr", addr_a, 32'h0000_0104);
        chk1("bubble_req", req_a, 1'b1);
        imem_ack = 1'b1;
        tick();
        chk("refetch_ir", ir_a, 32'h0000_0104);
        chk1("refetch_valid", valid_a, 1'b1);
        chk("refetch_addr", addr_a, 32'h0000_0108);

        branch_taken = 1'b1; branch_target = 32'h0000_0102;
        tick();
        branch_taken = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        chk1("mis_fault", fault_a, 1'b1);
        chk1("mis_req", req_a, 1'b0);
        chk1("mis_valid", valid_a, 1'b0);
        tick();
        chk1("mis_fault_hold", fault_a, 1'b1);
        chk1("mis_req_hold", req_a, 1'b0);
`else
        chk("mis_addr", addr_a, 32'h0000_0100);
        chk1("mis_fault", fault_a, 1'b0);
        chk1("mis_valid", valid_a, 1'b0);
        chk1("mis_req", req_a, 1'b1);
        tick();
        chk("mis_fetch_ir", ir_a, 32'h0000_0100);
        chk("mis_fetch_pc", pcout_a, 32'h0000_0100);
        chk1("mis_fetch_valid", valid_a, 1'b1);
        chk("mis_fetch_addr", addr_a, 32'h0000_0104);
`endif

        stall = 1'b1;
        tick();
        chk1("hold_req", req_a, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_a("rst_hold");
        #1;
        rst = 1'b0;
        stall = 1'b0;
        imem_ack = 1'b1;
        tick();
        chk("post_rst_ir", ir_a, 32'h0000_0000);
        chk("post_rst_pc", pcout_a, 32'h0000_0000);
        chk1("post_rst_valid", valid_a, 1'b1);
        chk("post_rst_addr", addr_a, 32'h0000_0004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_fsm.md
FETCH_FSM -- requirements
Module: fetch_fsm

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, PC loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  32  fetch address, always equal to internal PC.
REQ-006 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-007 imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-008 stall  input  1  read stage not accepting IR_out/PC_out this cycle.
REQ-009 branch_taken  input  1  redirect request from execute stage.
REQ-010 branch_target  input  32  redirect address.
REQ-011 IR_out  output  32  fetched instruction to read stage.
REQ-012 PC_out  output  32  address of IR_out.
REQ-013 valid_out  output  1  IR_out/PC_out hold a live instruction.
REQ-014 fault  output  1  misaligned-redirect fault flag.

Function
REQ-015 States: S_REQ (request outstanding), S_HOLD (output stalled, no request), S_FAULT (halted).
REQ-016 imem_req SHALL be 1 in S_REQ only; 0 in S_HOLD and S_FAULT.
REQ-017 Per-cycle priority: rst > branch_taken > stall > imem_ack.
REQ-018 S_REQ, imem_ack=1, no branch, (stall=0 or valid_out=0): next edge IR_out<=imem_rdata, PC_out<=PC, valid_out<=1, PC<=PC+4 (one-cycle latency).
REQ-019 S_REQ, stall=1 and valid_out=1: ack ignored, outputs held, next state S_HOLD.
REQ-020 S_REQ, stall=0, valid_out=1, imem_ack=0: valid_out<=0 (bubble), outputs otherwise held.
REQ-021 S_HOLD: outputs and PC held; stall=0 returns to S_REQ next edge, valid_out stays 1 until consumed.
REQ-022 branch_taken=1 in S_REQ or S_HOLD: PC<=branch_target, valid_out<=0, same-cycle ack discarded, next state S_REQ.
REQ-023 PC arithmetic modulo 2^32: 32'hFFFFFFFC + 4 wraps to 32'h00000000.
REQ-024 imem_addr SHALL change only on a clock edge; memory tolerates abandoned requests after redirect.
REQ-025 S_FAULT exits only via rst.

Reset
REQ-026 rst asserted: immediately PC=RESET_PC, state S_REQ, IR_out=32'h00000013 (NOP), PC_out=0, valid_out=0, fault=0.
REQ-027 rst mid-request: outstanding request abandoned; first request after release uses RESET_PC.

Configuration
REQ-028 Macro FETCH_MISALIGN_CHECK_EN defined: branch_target[1:0]!=0 with branch_taken=1 sets fault=1, valid_out<=0, next state S_FAULT.
REQ-029 Macro undefined: branch_target[1:0] forced to 0 on load, fault tied 0, S_FAULT unreachable.

Structure
REQ-030 Shared package riscv_pkg holds state enum, NOP constant 32'h00000013, instruction width 32, PC increment 4.
REQ-031 One combinational sub-module pc_next: selects RESET_PC / aligned branch_target / PC+4 / PC.

Verification
REQ-032 Reset release, ack every cycle, rdata=addr -> IR_out/PC_out 0,4,8,... one cycle after each ack, valid_out=1 continuous.
REQ-033 stall=1 for 3 cycles while valid_out=1 -> IR_out/PC_out constant, imem_req=0 after first stalled cycle, no PC advance; resumes at next address.
REQ-034 branch_taken=1, branch_target=32'h00000100 coincident with ack -> acked word dropped, valid_out=0 next cycle, imem_addr=0x100.
REQ-035 RESET_PC=32'hFFFFFFFC, ack -> PC_out=0xFFFFFFFC, next imem_addr=0x00000000.
REQ-036 With FETCH_MISALIGN_CHECK_EN, target 32'h00000102 -> fault=1, imem_req=0 until rst; without macro -> imem_addr=0x100, fault=0.
REQ-037 rst pulsed mid-S_HOLD -> outputs immediately at reset values, imem_addr=RESET_PC.
